// File: rtl/edge_loader.sv
// edge_loader: stream-to-memory loader that sits in front of the CGRA routing FSM.
// It collects one batch of packed routing edges from a valid/ready stream into an
// edge buffer. It then pulses start to the router and serves the router's edge
// reads from that buffer. The buffer stays frozen until router_done releases it.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset (0 = in reset)
//   in_valid     upstream beat valid
//   in_ready     loader can accept a beat (registered, depends on state only)
//   in_edge      edge word: [7:4] source PE, [3:0] destination PE
//   in_last      final beat of the batch
//   start        one-cycle pulse once the batch is committed
//   router_done  router finished with the batch (honoured only while holding)
//   rd_addr      router read index
//   rd_data      edge at rd_addr, or 0 when rd_addr >= edge_count (combinational)
//   edge_count   number of stored edges, saturating at DEPTH
//   overflow     sticky flag: the current batch exceeded DEPTH
//
// Build option
//   EDGE_LOADER_SELF_LOOP_DROP_EN: when defined, self-loop edges (source == destination)
//   are handshaken but not stored and do not count toward overflow.
module edge_loader #(
  parameter int unsigned DEPTH  = 11,
  parameter int unsigned EDGE_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EDGE_W-1:0] in_edge,
  input  logic              in_last,
  output logic              start,
  input  logic              router_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [EDGE_W-1:0] rd_data,
  output logic [ADDR_W-1:0] edge_count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DRAIN,
    S_START,
    S_HOLD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [EDGE_W-1:0] mem [DEPTH];

  logic accept_c;     // beat handshake this cycle
  logic store_c;      // beat is eligible for storage
  logic load_beat_c;  // accepted beat while filling the buffer
  logic fill_c;       // accepted beat occupies the last buffer slot

  assign accept_c    = in_valid & in_ready;
  assign load_beat_c = accept_c & (state == S_LOAD);
  assign fill_c      = load_beat_c & store_c & (edge_count == LAST_IDX);

`ifdef EDGE_LOADER_SELF_LOOP_DROP_EN
  localparam int unsigned HALF_W = EDGE_W / 2;
  // Self-loop edges carry no routing work; drop them silently.
  assign store_c = (in_edge[EDGE_W-1:HALF_W] != in_edge[HALF_W-1:0]);
`else
  assign store_c = 1'b1;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (accept_c) begin
          if (in_last) begin
            state_nxt = S_START;
          end else if (fill_c) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (accept_c && in_last) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (router_done) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // State, handshake and status registers; outputs follow the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_LOAD;
      in_ready   <= 1'b0;
      start      <= 1'b0;
      edge_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == S_LOAD) || (state_nxt == S_DRAIN);
      start    <= (state_nxt == S_START);

      // Overflow can only be set on the way out of S_LOAD, so any accepted beat
      // while loading is necessarily in the batch that must clear a stale flag.
      if (load_beat_c) begin
        overflow <= fill_c & ~in_last;
        if (store_c) begin
          edge_count <= edge_count + ADDR_W'(1);
        end
      end

      if ((state == S_HOLD) && router_done) begin
        edge_count <= '0;
      end
    end
  end

  // Edge buffer: not reset; stale words are masked by edge_count on reads
  always_ff @(posedge clk) begin
    if (load_beat_c && store_c) begin
      mem[edge_count] <= in_edge;
    end
  end

  // Zero past the stored range doubles as the router's end-of-list terminator
  assign rd_data = (rd_addr < edge_count) ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_edge_loader.sv
// Self-checking bench for edge_loader: directed scenarios followed by random batches,
// all compared each cycle against a queue-based reference model of the edge buffer.
module tb_edge_loader;

  localparam int unsigned DEPTH  = 11;
  localparam int unsigned EDGE_W = 8;
  localparam int unsigned ADDR_W = 4;

`ifdef EDGE_LOADER_SELF_LOOP_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [EDGE_W-1:0] in_edge;
  logic              in_last;
  logic              start;
  logic              router_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [EDGE_W-1:0] rd_data;
  logic [ADDR_W-1:0] edge_count;
  logic              overflow;

  edge_loader #(.DEPTH(DEPTH), .EDGE_W(EDGE_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_edge    (in_edge),
    .in_last    (in_last),
    .start      (start),
    .router_done(router_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .edge_count (edge_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: stored edges as a queue plus batch phase
  typedef enum int {P_LOAD, P_START, P_HOLD} phase_t;
  logic [7:0] q[$];
  phase_t     phase;
  bit         ready_m;
  bit         start_m;
  bit         ovf_m;
  int         beats_m;

  function automatic bit is_drop(input logic [7:0] e);
    return DROP && (e[7:4] == e[3:0]);
  endfunction

  task automatic model_reset();
    q.delete();
    phase   = P_LOAD;
    ready_m = 1'b0;
    start_m = 1'b0;
    ovf_m   = 1'b0;
    beats_m = 0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] e, input bit l, input bit rd,
                            output bit acc);
    acc = v && ready_m;
    case (phase)
      P_LOAD: begin
        if (acc) begin
          if (beats_m == 0) ovf_m = 1'b0;
          beats_m++;
          if (!is_drop(e) && q.size() < DEPTH) begin
            q.push_back(e);
            if (q.size() == DEPTH && !l) ovf_m = 1'b1;
          end
          if (l) begin
            phase   = P_START;
            beats_m = 0;
          end
        end
      end
      P_START: phase = P_HOLD;
      P_HOLD: begin
        if (rd) begin
          q.delete();
          phase = P_LOAD;
        end
      end
      default: phase = P_LOAD;
    endcase
    ready_m = (phase == P_LOAD);
    start_m = (phase == P_START);
  endtask

  function automatic logic [7:0] model_rd(input int a);
    return (a < q.size()) ? q[a] : 8'h00;
  endfunction

  task automatic check_outs();
    check("in_ready", 32'(in_ready), 32'(ready_m));
    check("start", 32'(start), 32'(start_m));
    check("edge_count", 32'(edge_count), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  // One clock: drive inputs, check the read port, clock, update model, check outputs
  task automatic cycle(input bit v, input logic [7:0] e, input bit l, input bit rd,
                       output bit acc);
    in_valid    = v;
    in_edge     = e;
    in_last     = l;
    router_done = rd;
    rd_addr     = 4'($urandom_range(0, 15));
    #1;
    check("rd_data", 32'(rd_data), 32'(model_rd(int'(rd_addr))));
    @(posedge clk);
    model_edge(v, e, l, rd, acc);
    #1;
    check_outs();
  endtask

  task automatic send_beat(input logic [7:0] e, input bit l, input bit gaps, input bit rd);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 32) begin
      bit v;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(v, e, l, rd, acc);
      tries++;
    end
    if (!acc) check("beat_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input bit rd);
    bit acc;
    cycle(1'b0, 8'h00, 1'b0, rd, acc);
  endtask

  task automatic peek(input int a, input logic [7:0] exp, input string tag);
    rd_addr = 4'(a);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  function automatic logic [7:0] rand_edge();
    logic [3:0] n;
    if (DROP && $urandom_range(0, 4) == 0) begin
      n = 4'($urandom_range(0, 15));
      return {n, n};
    end
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bit acc;
    logic [7:0] t1_exp [4];
    t1_exp[0] = 8'h12; t1_exp[1] = 8'h34; t1_exp[2] = 8'h56; t1_exp[3] = 8'h00;

    reset = 1'b0; in_valid = 1'b0; in_edge = '0; in_last = 1'b0;
    router_done = 1'b0; rd_addr = '0;
    model_reset();
    #12;
    check_outs();
    reset = 1'b1;

    // Basic three-beat batch
    send_beat(8'h12, 1'b0, 1'b0, 1'b0);
    send_beat(8'h34, 1'b0, 1'b0, 1'b0);
    send_beat(8'h56, 1'b1, 1'b0, 1'b0);
    check("t1_start", 32'(start), 32'(1));
    check("t1_count", 32'(edge_count), 32'(3));
    for (int i = 0; i < 4; i++) peek(i, t1_exp[i], "t1_rd");

    // Beat held during hold is stalled, then lands in slot 0 after release
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h9A, 1'b0, 1'b0, acc);
    check("hold_ready", 32'(in_ready), 32'(0));
    for (int i = 0; i < 3; i++) peek(i, t1_exp[i], "hold_rd");
    cycle(1'b1, 8'h9A, 1'b0, 1'b1, acc);
    check("rel_count", 32'(edge_count), 32'(0));
    cycle(1'b1, 8'h9A, 1'b0, 1'b0, acc);
    peek(0, 8'h9A, "held_beat");
    send_beat(8'h9B, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Oversized batch: 13 beats, 11 stored
    for (int i = 0; i < 13; i++)
      send_beat(8'(8'h01 + 8'h11 * i), i == 12, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'(1));
    check("ovf_count", 32'(edge_count), 32'(DEPTH));
    peek(10, 8'hAB, "ovf_last_slot");
    idle(1'b0);
    idle(1'b1);
    check("ovf_sticky", 32'(overflow), 32'(1));
    send_beat(8'h21, 1'b0, 1'b0, 1'b0);
    check("ovf_clear", 32'(overflow), 32'(0));
    send_beat(8'h32, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Single self-loop beat
    send_beat(8'h77, 1'b1, 1'b0, 1'b0);
    check("sl_start", 32'(start), 32'(1));
    check("sl_count", 32'(edge_count), DROP ? 32'(0) : 32'(1));
    peek(0, DROP ? 8'h00 : 8'h77, "sl_rd");
    idle(1'b0);
    idle(1'b1);

    // router_done while loading is ignored
    send_beat(8'h45, 1'b0, 1'b0, 1'b1);
    send_beat(8'h56, 1'b0, 1'b0, 1'b1);
    check("rd_ignored", 32'(edge_count), 32'(2));

    // Reset arrives in the same cycle as the last beat
    in_valid = 1'b1; in_edge = 8'h67; in_last = 1'b1; router_done = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outs();
    #2 reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    check_outs();
    idle(1'b0);
    check("rst_ready", 32'(in_ready), 32'(1));
    idle(1'b0);

    // Random batches with gaps, random router timing and traffic during hold
    for (int b = 0; b < 40; b++) begin
      int len;
      int wait_n;
      len = $urandom_range(1, 15);
      for (int i = 0; i < len; i++)
        send_beat(rand_edge(), i == len - 1, 1'b1, $urandom_range(0, 7) == 0);
      wait_n = $urandom_range(1, 5);
      for (int i = 0; i < wait_n; i++)
        cycle($urandom_range(0, 1) == 1, rand_edge(), 1'b0, 1'b0, acc);
      idle(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/edge_loader.md
# edge_loader

Stream-to-memory loader directly upstream of the CGRA routing FSM. It accepts one batch of packed routing edges over a valid/ready stream and stores them in an edge buffer. It then pulses `start` to the router and serves the router's edge reads from that buffer. The buffer is frozen until the router signals completion, and only then does the block accept the next batch.

## Interface
- `DEPTH`, 11: edge buffer entries (router edge-memory depth).
- `EDGE_W`, 8: edge word width; `[7:4]` = source PE, `[3:0]` = destination PE.
- `ADDR_W`, 4: buffer address / count width; must satisfy 2^ADDR_W > DEPTH.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `in_valid`  in  1  upstream edge beat valid.
- `in_ready`  out  1  loader can accept a beat.
- `in_edge`  in  EDGE_W  edge word.
- `in_last`  in  1  final beat of the batch.
- `start`  out  1  one-cycle pulse: batch committed, router may begin.
- `router_done`  in  1  router finished with the batch; releases the buffer.
- `rd_addr`  in  ADDR_W  router read index.
- `rd_data`  out  EDGE_W  edge at `rd_addr`; 0 when `rd_addr >= edge_count`.
- `edge_count`  out  ADDR_W  number of stored edges.
- `overflow`  out  1  sticky: the current batch exceeded `DEPTH`.

## Operation
- States: `S_LOAD`, `S_DRAIN`, `S_START`, `S_HOLD`.
- **S_LOAD**
  - `in_ready=1`.
  - On an accepted beat: `mem[edge_count] <= in_edge`, `edge_count++`.
  - The first accepted beat of a batch clears `overflow`.
  - `in_last` → `S_START`.
  - Beat accepted at `edge_count==DEPTH-1` without `in_last`: store it, set `overflow=1`, go to `S_DRAIN`.
- **S_DRAIN**
  - `in_ready=1`.
  - Accepted beats are discarded.
  - Accepted beat with `in_last` → `S_START`.
- **S_START**
  - `in_ready=0`, `start=1` for exactly one cycle.
  - Next state is `S_HOLD`.
- **S_HOLD**
  - `in_ready=0`; buffer and `edge_count` are stable.
  - `router_done=1` → `edge_count <= 0`, then `S_LOAD`.
- `router_done` is ignored outside `S_HOLD`.
- `rd_data` is combinational: `mem[rd_addr]` if `rd_addr < edge_count`, otherwise 0. The zero word is the router's end-of-list terminator.
- `edge_count` saturates at `DEPTH` and never wraps.
- Buffer RAM is not reset. Stale entries are masked by the `edge_count` gating.

## Timing
- Reset values: state `S_LOAD`, `edge_count=0`, `start=0`, `overflow=0`, `in_ready=0` while `reset=0`.
- `in_ready=1` from the first cycle after `reset` deasserts.
- `in_ready` depends only on state, never on `in_valid`.
- Beat accepted on the rising edge where `in_valid & in_ready`.
- Last beat accepted at edge N → `start` high during cycle N..N+1 → `S_HOLD` from edge N+1. `rd_data` for all stored edges is valid from edge N.
- `router_done` sampled at edge M in `S_HOLD` → `in_ready=1` and `edge_count=0` after edge M.
- Asynchronous reset mid-batch or during `S_HOLD` aborts immediately. A pending `start` never fires, and the partial batch is lost.

## Configuration
- `EDGE_LOADER_SELF_LOOP_DROP_EN`
  - Defined: a beat with `in_edge[7:4]==in_edge[3:0]` is handshaken normally but not stored. `edge_count` is not incremented, and the beat does not count toward overflow. Its `in_last` still ends the batch, so `start` can fire with `edge_count=0`.
  - Undefined: every beat is stored unchanged.

## Test plan
- Reset, then 3 beats 0x12, 0x34, 0x56 (`last` on the third) → `start` pulses once. `edge_count=3`; `rd_data` for addr 0..3 = 0x12, 0x34, 0x56, 0x00.
- Beats presented during `S_HOLD` with `in_valid` held high → `in_ready=0`, buffer unchanged. After a `router_done` pulse, the held beat is accepted into addr 0.
- 13-beat batch (`last` on the 13th) → 11 stored, `overflow=1`, beats 12–13 discarded, then `start`. `overflow` clears on the first beat of the next batch.
- Single beat 0x77 with `last`: with `EDGE_LOADER_SELF_LOOP_DROP_EN`, `edge_count=0` and `start` still pulses; without it, `edge_count=1` and `rd_data[0]=0x77`.
- `reset` asserted the same cycle a last beat is accepted → no `start`, `edge_count=0`, `in_ready=1` after release.
- `router_done` asserted in `S_LOAD` mid-batch → ignored; `edge_count` keeps incrementing.
